layer_feed: RTL and testbench

LAYER_FEED -- requirements
Module: layer_feed

---
 rtl/layer_pkg.sv | 26 ++
 rtl/layer_feed.sv | 143 ++++++++++++++
 tb/tb_layer_feed.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : layer_pkg                                                    |
// | Description : Shared definitions for the layer front end: default vector   |
// |               length and sample width, layer output count, the signed      |
// |               sample type and the feeder FSM state encoding.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package layer_pkg;

  localparam int DW    = 16;  // signed sample width
  localparam int N_IN  = 64;  // input vector length of the layer
  localparam int N_OUT = 32;  // output vector length of the layer

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_FILL      = 3'd0,  // collecting samples of a frame
    ST_DROP      = 3'd1,  // discarding the tail of an over-long frame
    ST_ISSUE     = 3'd2,  // full vector held, waiting for the layer to be idle
    ST_WAIT_ACK  = 3'd3,  // start issued, waiting for the layer to go busy
    ST_WAIT_DONE = 3'd4   // layer busy, waiting for it to finish
  } state_t;

endpackage : layer_pkg
`default_nettype wire

// File: rtl/layer_feed.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : layer_feed                                                   |
// | Description : Collects a frame of N_IN signed samples from a valid/ready   |
// |               stream into a parallel vector and starts the layer with a    |
// |               one-cycle valid_in pulse once the layer reports idle.        |
// |               Short and long frames are rejected with a frame_err pulse.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   rising-edge clock                                        |
// |   reset      in   synchronous active-high reset                            |
// |   s_valid    in   upstream sample valid                                    |
// |   s_data     in   upstream signed sample [DW]                              |
// |   s_last     in   final sample of a frame                                  |
// |   s_ready    out  sample accepted this cycle when s_valid is high          |
// |   input_data out  parallel vector to the layer [N_IN][DW]                  |
// |   valid_in   out  one-cycle start pulse to the layer                       |
// |   ready_out  in   layer idle/ready                                         |
// |   frame_err  out  one-cycle pulse per malformed frame                      |
// +----------------------------------------------------------------------------+
module layer_feed
  import layer_pkg::*;
#(
  parameter int N_IN = layer_pkg::N_IN,
  parameter int DW   = layer_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic signed [DW-1:0] input_data [N_IN],
  output logic                 valid_in,
  input  logic                 ready_out,
  output logic                 frame_err
);

  localparam int                CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_IN - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic signed [DW-1:0]   r_data [N_IN];
  logic                   r_valid_in;
  logic                   r_frame_err;
  logic                   w_accept;
  logic                   w_wr_en;
  logic                   w_issue;
  logic                   w_frame_err;

  // Ready is decoded from the registered state only, so it never depends
  // combinationally on s_valid or ready_out.
  assign s_ready  = (r_state == ST_FILL) || (r_state == ST_DROP);
  assign w_accept = s_valid && s_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_issue     = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (r_cnt == C_LAST) begin
            w_cnt_nxt = '0;
            if (s_last) begin
              w_state_nxt = ST_ISSUE;
            end else begin
              // Vector full but frame continues: reject and skip to its end.
              w_frame_err = 1'b1;
              w_state_nxt = ST_DROP;
            end
          end else if (s_last) begin
            // Frame ended early: reject and restart collection in place.
            w_frame_err = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_DROP: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_ISSUE: begin
        if (ready_out) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // The layer drops ready_out once it has taken the start pulse.
        if (!ready_out) begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // The vector must stay stable until the layer is idle again.
        if (ready_out) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_cnt       <= '0;
      r_valid_in  <= 1'b0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_valid_in  <= w_issue;
      r_frame_err <= w_frame_err;
      if (w_wr_en) begin
        r_data[r_cnt] <= s_data;
      end
    end
  end

  assign input_data = r_data;
  assign valid_in   = r_valid_in;
  assign frame_err  = r_frame_err;

endmodule : layer_feed
`default_nettype wire

// File: tb/tb_layer_feed.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_layer_feed                                                |
// | Description : Directed self-checking bench for layer_feed.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_layer_feed;

  localparam int N = 64;
  localparam int W = 16;

  logic                clk       = 1'b0;
  logic                reset     = 1'b1;
  logic                s_valid   = 1'b0;
  logic signed [W-1:0] s_data    = '0;
  logic                s_last    = 1'b0;
  logic                ready_out = 1'b1;
  logic                s_ready;
  logic signed [W-1:0] input_data [N];
  logic                valid_in;
  logic                frame_err;

  int n_pass  = 0;
  int n_total = 0;
  int v_cnt   = 0;
  int e_cnt   = 0;
  int both_cnt = 0;

  layer_feed #(.N_IN(N), .DW(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .input_data (input_data),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters; tests compare deltas against snapshots.
  always @(posedge clk) begin
    if (valid_in) v_cnt <= v_cnt + 1;
    if (frame_err) e_cnt <= e_cnt + 1;
    if (valid_in && frame_err) both_cnt <= both_cnt + 1;
  end

  // Sample patterns, each hand-chosen so consecutive tests leave distinct data.
  function automatic logic signed [W-1:0] pat(input int kind, input int k);
    case (kind)
      0:       return 16'(k * 100);
      1:       return 16'(k * 3 - 50);
      2:       return 16'(1000 + k);
      3:       return 16'(k * 5 + 1);
      4:       return (k % 2 == 0) ? 16'sh8000 : 16'sh7FFF;
      5:       return 16'sd7777;
      6:       return 16'sd9999;
      default: return 16'(-k * 250);
    endcase
  endfunction

  function automatic int count_bad(input int kind, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (input_data[k] !== pat(kind, k)) bad++;
    end
    return bad;
  endfunction

  function automatic int count_nonzero();
    int nz = 0;
    for (int k = 0; k < N; k++) begin
      if (input_data[k] !== '0) nz++;
    end
    return nz;
  endfunction

  task automatic push(input logic signed [W-1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_frame(input int kind, input int n, input int last_idx);
    for (int k = 0; k < n; k++) push(pat(kind, k), k == last_idx);
  endtask

  // Layer takes the start (ready_out low) and then finishes (ready_out high).
  task automatic handshake_done();
    ready_out = 1'b0;
    @(posedge clk); #1;
    ready_out = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_total++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready got=%b exp=1", s_ready); else n_pass++;
    n_total++; if (valid_in !== 1'b0) $display("FAIL rst_valid_in got=%b exp=0", valid_in); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err got=%b exp=0", frame_err); else n_pass++;
    n_total++; if (count_nonzero() !== 0) $display("FAIL rst_data nonzero=%0d exp=0", count_nonzero()); else n_pass++;
  endtask

  task automatic test_normal();
    int v0;
    v0 = v_cnt;
    ready_out = 1'b1;
    push_frame(0, N, N - 1);
    n_total++; if (valid_in !== 1'b0) $display("FAIL norm_early_valid got=%b exp=0", valid_in); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL norm_issue_ready got=%b exp=0", s_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (valid_in !== 1'b1) $display("FAIL norm_valid_lat2 got=%b exp=1", valid_in); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (valid_in !== 1'b0) $display("FAIL norm_valid_width got=%b exp=0", valid_in); else n_pass++;
    n_total++; if (v_cnt - v0 !== 1) $display("FAIL norm_valid_count got=%0d exp=1", v_cnt - v0); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL norm_ack_ready got=%b exp=0", s_ready); else n_pass++;
    ready_out = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_total++; if (s_ready !== 1'b0) $display("FAIL norm_done_ready got=%b exp=0", s_ready); else n_pass++;
    ready_out = 1'b1;
    @(posedge clk); #1;
    n_total++; if (s_ready !== 1'b1) $display("FAIL norm_back_to_fill got=%b exp=1", s_ready); else n_pass++;
    n_total++; if (count_bad(0, N) !== 0) $display("FAIL norm_data bad=%0d exp=0", count_bad(0, N)); else n_pass++;
  endtask

  task automatic test_busy();
    int v0;
    push_frame(1, N - 1, -1);
    ready_out = 1'b0;
    push(pat(1, N - 1), 1'b1);
    v0 = v_cnt;
    repeat (20) @(posedge clk); #1;
    n_total++; if (v_cnt - v0 !== 0) $display("FAIL busy_no_valid got=%0d exp=0", v_cnt - v0); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL busy_ready got=%b exp=0", s_ready); else n_pass++;
    ready_out = 1'b1;
    @(posedge clk); #1;
    n_total++; if (valid_in !== 1'b1) $display("FAIL busy_valid got=%b exp=1", valid_in); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (v_cnt - v0 !== 1) $display("FAIL busy_valid_count got=%0d exp=1", v_cnt - v0); else n_pass++;
    handshake_done();
    n_total++; if (count_bad(1, N) !== 0) $display("FAIL busy_data bad=%0d exp=0", count_bad(1, N)); else n_pass++;
  endtask

  task automatic test_short();
    int v0, e0;
    v0 = v_cnt; e0 = e_cnt;
    push_frame(5, 11, 10);
    n_total++; if (frame_err !== 1'b1) $display("FAIL short_err got=%b exp=1", frame_err); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL short_ready got=%b exp=1", s_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (frame_err !== 1'b0) $display("FAIL short_err_width got=%b exp=0", frame_err); else n_pass++;
    push_frame(7, N, N - 1);
    repeat (2) @(posedge clk); #1;
    n_total++; if (v_cnt - v0 !== 1) $display("FAIL short_next_valid got=%0d exp=1", v_cnt - v0); else n_pass++;
    n_total++; if (e_cnt - e0 !== 1) $display("FAIL short_err_count got=%0d exp=1", e_cnt - e0); else n_pass++;
    handshake_done();
    n_total++; if (count_bad(7, N) !== 0) $display("FAIL short_next_data bad=%0d exp=0", count_bad(7, N)); else n_pass++;
  endtask

  task automatic test_long();
    int v0, e0;
    v0 = v_cnt; e0 = e_cnt;
    push_frame(2, N, -1);
    n_total++; if (frame_err !== 1'b1) $display("FAIL long_err got=%b exp=1", frame_err); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL long_drop_ready got=%b exp=1", s_ready); else n_pass++;
    push_frame(6, 5, 4);
    repeat (2) @(posedge clk); #1;
    n_total++; if (e_cnt - e0 !== 1) $display("FAIL long_err_count got=%0d exp=1", e_cnt - e0); else n_pass++;
    n_total++; if (v_cnt - v0 !== 0) $display("FAIL long_no_valid got=%0d exp=0", v_cnt - v0); else n_pass++;
    n_total++; if (count_bad(2, N) !== 0) $display("FAIL long_extra_written bad=%0d exp=0", count_bad(2, N)); else n_pass++;
    push_frame(0, N, N - 1);
    repeat (2) @(posedge clk); #1;
    n_total++; if (v_cnt - v0 !== 1) $display("FAIL long_next_valid got=%0d exp=1", v_cnt - v0); else n_pass++;
    handshake_done();
    n_total++; if (count_bad(0, N) !== 0) $display("FAIL long_next_data bad=%0d exp=0", count_bad(0, N)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int v0;
    push_frame(3, 31, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++; if (s_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", s_ready); else n_pass++;
    n_total++; if (count_nonzero() !== 0) $display("FAIL midrst_data nonzero=%0d exp=0", count_nonzero()); else n_pass++;
    v0 = v_cnt;
    push_frame(3, N, N - 1);
    repeat (2) @(posedge clk); #1;
    n_total++; if (v_cnt - v0 !== 1) $display("FAIL midrst_next_valid got=%0d exp=1", v_cnt - v0); else n_pass++;
    handshake_done();
    n_total++; if (count_bad(3, N) !== 0) $display("FAIL midrst_next_data bad=%0d exp=0", count_bad(3, N)); else n_pass++;
    // Reset while a start is pending must cancel it.
    ready_out = 1'b0;
    push_frame(1, N, N - 1);
    @(posedge clk); #1;
    reset = 1'b1;
    ready_out = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    v0 = v_cnt;
    repeat (4) @(posedge clk); #1;
    n_total++; if (v_cnt - v0 !== 0) $display("FAIL hsrst_no_valid got=%0d exp=0", v_cnt - v0); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL hsrst_ready got=%b exp=1", s_ready); else n_pass++;
  endtask

  task automatic test_extremes();
    push_frame(4, N, N - 1);
    repeat (2) @(posedge clk); #1;
    handshake_done();
    n_total++; if (input_data[0] !== 16'sh8000) $display("FAIL ext_min got=%h exp=8000", input_data[0]); else n_pass++;
    n_total++; if (input_data[N-1] !== 16'sh7FFF) $display("FAIL ext_max got=%h exp=7fff", input_data[N-1]); else n_pass++;
    n_total++; if (count_bad(4, N) !== 0) $display("FAIL ext_data bad=%0d exp=0", count_bad(4, N)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_busy();
    test_short();
    test_long();
    test_reset_mid();
    test_extremes();
    n_total++; if (both_cnt !== 0) $display("FAIL err_with_valid got=%0d exp=0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_layer_feed
`default_nettype wire
